// File: rtl/apb_spi_pkg.sv
// Shared constants for the APB SPI register block: register indices, reset values,
// write masks, spi_mode encodings and the APB slave state type.
package apb_spi_pkg;

    localparam logic [2:0] IDX_CR1 = 3'd0;
    localparam logic [2:0] IDX_CR2 = 3'd1;
    localparam logic [2:0] IDX_BR  = 3'd2;
    localparam logic [2:0] IDX_SR  = 3'd3;
    localparam logic [2:0] IDX_DR  = 3'd4;
    localparam logic [2:0] IDX_LVL = 3'd5;

    localparam logic [7:0] CR1_RESET = 8'h04;
    localparam logic [7:0] CR2_RESET = 8'h00;
    localparam logic [7:0] BR_RESET  = 8'h00;
    localparam logic [7:0] CR2_WMASK = 8'h1B;
    localparam logic [7:0] BR_WMASK  = 8'h77;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_WAIT = 2'b01;
    localparam logic [1:0] MODE_STOP = 2'b10;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; a pop on the same edge as a
// push frees the slot, so a full FIFO still accepts a push paired with a pop.
module spi_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign dout   = mem_q[rdPtr_q];
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= din;
    end

endmodule

// File: rtl/apb_spi_regfile.sv
// APB3 register block for the SPI controller with TX/RX FIFOs and level/status registers.
// Define APB_SPI_PSLVERR_EN to report erroneous accesses on PSLVERR; otherwise PSLVERR is 0.
module apb_spi_regfile import apb_spi_pkg::*; #(
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              PClk,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [2:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic              SS,
    input  logic              tip,
    input  logic              wait_req,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_pop,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_push,
    output logic              mstr,
    output logic              cpol,
    output logic              cpha,
    output logic              lsbfe,
    output logic              spiswai,
    output logic              ssoe,
    output logic              spe,
    output logic [2:0]        sppr,
    output logic [2:0]        spr,
    output logic [1:0]        spi_mode,
    output logic              spi_interrupt_request
);

    apb_state_e        state_q, state_d;
    logic [7:0]        cr1_q, cr2_q, br_q;
    logic              rxovr_q;
    logic              access, wrEn, rdEn, cfgWrOk, cr1Wr, flush;
    logic              txPush, rxPop, rxOverflow;
    logic              txFull, txEmpty, rxFull, rxEmpty;
    logic [DATA_W-1:0] rxDout;
    logic [CNT_W-1:0]  txCount, rxCount;
    logic              spie, sptie, modfen, modf, spif, sptef;
    logic [7:0]        srValue;
    logic [31:0]       rdata;
    logic              unusedPwdata;

    assign unusedPwdata = ^PWDATA;

    always_comb begin
        state_d = state_q;
        case (state_q)
            APB_IDLE:   if (PSEL && !PENABLE) state_d = APB_SETUP;
            APB_SETUP:  state_d = APB_ACCESS;
            APB_ACCESS: state_d = (PSEL && !PENABLE) ? APB_SETUP : APB_IDLE;
            default:    state_d = APB_IDLE;
        endcase
    end

    always_ff @(posedge PClk) begin
        if (PRESET) state_q <= APB_IDLE;
        else        state_q <= state_d;
    end

    assign access  = (state_q == APB_ACCESS) && PSEL && PENABLE;
    assign wrEn    = access && PWRITE;
    assign rdEn    = access && !PWRITE;
    assign cfgWrOk = wrEn && !tip;
    assign cr1Wr   = cfgWrOk && (PADDR == IDX_CR1);
    // Turning the block off discards everything queued in both directions.
    assign flush   = cr1Wr && cr1_q[6] && !PWDATA[6];
    assign txPush  = wrEn && (PADDR == IDX_DR);
    assign rxPop   = rdEn && (PADDR == IDX_DR);
    assign rxOverflow = rx_push && rxFull && !rxPop;

    always_ff @(posedge PClk) begin
        if (PRESET) begin
            cr1_q   <= CR1_RESET;
            cr2_q   <= CR2_RESET;
            br_q    <= BR_RESET;
            rxovr_q <= 1'b0;
        end else begin
            if (cr1Wr) cr1_q <= PWDATA[7:0];
            if (cfgWrOk && (PADDR == IDX_CR2)) cr2_q <= PWDATA[7:0] & CR2_WMASK;
            if (cfgWrOk && (PADDR == IDX_BR))  br_q  <= PWDATA[7:0] & BR_WMASK;
            if (rxOverflow)
                rxovr_q <= 1'b1;
            else if (wrEn && (PADDR == IDX_SR) && PWDATA[6])
                rxovr_q <= 1'b0;
        end
    end

    spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_txFifo (
        .clk(PClk), .rst(PRESET), .push(txPush), .pop(tx_pop), .flush(flush),
        .din(PWDATA[DATA_W-1:0]), .dout(tx_data), .full(txFull), .empty(txEmpty),
        .count(txCount)
    );

    spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rxFifo (
        .clk(PClk), .rst(PRESET), .push(rx_push), .pop(rxPop), .flush(flush),
        .din(rx_data), .dout(rxDout), .full(rxFull), .empty(rxEmpty),
        .count(rxCount)
    );

    assign spie    = cr1_q[7];
    assign spe     = cr1_q[6];
    assign sptie   = cr1_q[5];
    assign mstr    = cr1_q[4];
    assign cpol    = cr1_q[3];
    assign cpha    = cr1_q[2];
    assign ssoe    = cr1_q[1];
    assign lsbfe   = cr1_q[0];
    assign modfen  = cr2_q[4];
    assign spiswai = cr2_q[1];
    assign sppr    = br_q[6:4];
    assign spr     = br_q[2:0];

    assign modf     = !SS && mstr && modfen && !ssoe;
    assign spif     = !rxEmpty;
    assign sptef    = !txFull;
    assign tx_valid = !txEmpty;
    assign srValue  = {spif, rxovr_q, sptef, modf, txEmpty, 3'b000};
    assign spi_interrupt_request = (spie && (spif || modf || rxovr_q)) || (sptie && sptef);

    always_comb begin
        if (!spe)                     spi_mode = MODE_STOP;
        else if (spiswai && wait_req) spi_mode = MODE_WAIT;
        else                          spi_mode = MODE_RUN;
    end

    always_comb begin
        rdata = '0;
        case (PADDR)
            IDX_CR1: rdata[7:0] = cr1_q;
            IDX_CR2: rdata[7:0] = cr2_q;
            IDX_BR:  rdata[7:0] = br_q;
            IDX_SR:  rdata[7:0] = srValue;
            IDX_DR:  if (!rxEmpty) rdata[DATA_W-1:0] = rxDout;
            IDX_LVL: begin
                rdata[23:16] = 8'(rxCount);
                rdata[7:0]   = 8'(txCount);
            end
            default: rdata = '0;
        endcase
    end

    assign PREADY = (state_q == APB_ACCESS) && !PRESET;
    assign PRDATA = PREADY ? rdata : 32'h0;

`ifdef APB_SPI_PSLVERR_EN
    logic errCond;

    always_comb begin
        errCond = 1'b0;
        case (PADDR)
            IDX_CR1, IDX_CR2, IDX_BR: errCond = PWRITE && tip;
            IDX_DR:                   errCond = PWRITE ? (txFull && !tx_pop) : rxEmpty;
            IDX_SR, IDX_LVL:          errCond = 1'b0;
            default:                  errCond = 1'b1;
        endcase
    end

    assign PSLVERR = access && !PRESET && errCond;
`else
    assign PSLVERR = 1'b0;
`endif

endmodule

// File: doc/apb_spi_regfile.md
# apb_spi_regfile

APB3 slave register block for the SPI controller, successor to the fixed 8-bit SPI register interface. Adds a parametrised data width, TX and RX FIFOs of configurable depth, sticky overrun status and a FIFO level register. Sits between the APB bus and the SPI shift/baud engine, exporting configuration fields and a FIFO-backed data stream.

## Interface
- DATA_W, 8, SPI frame and DR width (8, 16 or 32).
- FIFO_DEPTH, 4, entries per FIFO (power of two, 2..16).
- CNT_W, $clog2(FIFO_DEPTH)+1, FIFO count width (derived, not overridden).
- PClk  in  1  clock; everything is synchronous to its rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL, PENABLE, PWRITE  in  1  APB3 control.
- PADDR  in  3  register index.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data, valid in the ACCESS cycle.
- PREADY, PSLVERR  out  1  APB3 response.
- SS  in  1  slave-select pin level, used for mode fault.
- tip  in  1  transfer in progress from the SPI engine.
- wait_req  in  1  CPU wait-mode request.
- tx_data  out  DATA_W  TX FIFO head.
- tx_valid  out  1  TX FIFO not empty.
- tx_pop  in  1  engine consumes the head.
- rx_data  in  DATA_W  received frame.
- rx_push  in  1  engine delivers a frame.
- mstr, cpol, cpha, lsbfe, spiswai, ssoe, spe  out  1  CR1/CR2 fields.
- sppr, spr  out  3  baud-rate prescaler and divider.
- spi_mode  out  2  00 run, 01 wait, 10 stop.
- spi_interrupt_request  out  1  level interrupt.

## Operation
- Register map:
  - 0 CR1: bit 7 spie, bit 6 spe, bit 5 sptie, bit 4 mstr, bit 3 cpol, bit 2 cpha, bit 1 ssoe, bit 0 lsbfe. Reset value 0x04.
  - 1 CR2: write mask 0x1B; bit 4 modfen, bit 1 spiswai. Reset value 0x00.
  - 2 BR: write mask 0x77; bits 6:4 sppr, bits 2:0 spr. Reset value 0x00.
  - 3 SR: read-only except as noted. Bit 7 spif (RX not empty), bit 6 rxovr (sticky; writing 1 clears it), bit 5 sptef (TX not full), bit 4 modf, bit 3 txempty. Reset reads 0x28.
  - 4 DR: a write pushes PWDATA[DATA_W-1:0] into the TX FIFO; a read pops the RX FIFO and returns the head zero-extended to 32 bits.
  - 5 LVL: read-only; bits 23:16 hold rx_count, bits 7:0 hold tx_count.
  - Indices 6 and 7 are unmapped; they read 0 and ignore writes.
- modf = ~SS & mstr & modfen & ~ssoe.
- spi_mode: stop when !spe; wait when spiswai & wait_req; run otherwise.
- spi_interrupt_request = spie&(spif|modf|rxovr) | sptie&sptef.
- Boundary behaviour:
  - DR write when TX is full: the write is dropped.
  - rx_push when RX is full: the frame is dropped and rxovr is set.
  - DR read when RX is empty: returns 0 and does not pop.
  - Simultaneous push and pop on one FIFO: both take effect and the count is unchanged.
  - Writes to CR1, CR2 or BR while tip=1 are ignored.
  - A CR1 write that clears spe flushes both FIFOs on that edge.
- PRESET during any phase:
  - Registers return to their reset values and both FIFOs empty.
  - The APB FSM goes to IDLE.
  - PRDATA reads 0 and PREADY reads 0.

## Timing
- APB FSM states: IDLE, SETUP, ACCESS.
  - IDLE to SETUP on PSEL & !PENABLE.
  - SETUP to ACCESS unconditionally.
  - ACCESS to SETUP when PSEL & !PENABLE; otherwise ACCESS to IDLE.
- PREADY = 1 only in ACCESS, giving zero wait states.
- Register writes and DR push/pop commit on the PClk edge that ends the ACCESS cycle.
- PRDATA is combinational from the registers during ACCESS and 0 in all other states.
- TX push is visible on tx_valid one cycle after the ACCESS edge. An rx_push is visible in SR and LVL the cycle after.
- The status and interrupt outputs are combinational from registered state.

## Configuration
- APB_SPI_PSLVERR_EN defined: in ACCESS, PSLVERR = 1 for any of the following:
  - an unmapped index;
  - a DR write while TX is full;
  - a DR read while RX is empty;
  - a CR1, CR2 or BR write while tip=1.
- APB_SPI_PSLVERR_EN not defined: PSLVERR is tied to 0. The same accesses are silently ignored, or read 0.

## Structure
- Package apb_spi_pkg holds:
  - the register index constants;
  - the CR2 and BR write masks and the reset values;
  - the spi_mode encodings;
  - the APB state enum.
- Sub-module spi_sync_fifo, instantiated twice (TX and RX):
  - parameters WIDTH and DEPTH;
  - ports: push, pop, flush, din, dout, full, empty, count;
  - first-word-fall-through, synchronous reset;
  - pointers wrap modulo DEPTH.

## Test plan
- Reset then read indices 0..5 -> 0x04, 0x00, 0x00, 0x28, 0x00, 0x00; PREADY is high only in the ACCESS cycle.
- Write CR2 = 0xFF and BR = 0xFF -> readback 0x1B and 0x77; sppr = 7, spr = 7.
- DATA_W = 16, FIFO_DEPTH = 4: write DR 0xA5A5 five times -> LVL tx_count = 4, sptef = 0; the fifth write is dropped (PSLVERR = 1 if enabled); tx_data = 0xA5A5.
- Five rx_push (0x1..0x5) with no read -> rxovr = 1 and the interrupt is set with spie = 1; reads return 0x1..0x4, then 0; writing SR = 0x40 clears rxovr.
- tip = 1 and write CR1 = 0x50 -> CR1 stays 0x04; after tip falls, the same write gives mstr = 1 and spe = 1.
- mstr = 1, modfen = 1, ssoe = 0, SS = 0 -> SR bit 4 = 1. Clearing spe -> both FIFOs flush and spi_mode = 10.
